// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter: FSM state encoding,
// index-width helper and the round-robin winner search.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Upper bound on requesters the winner search can scan.
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned MAX_IDX_W = 5;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // First set request scanning upward from last+1 with wrap; 'last' itself is
  // checked last, so it only wins when it is the sole requester.
  function automatic int unsigned rr_winner(input logic [MAX_REQ-1:0] req,
                                            input int unsigned last,
                                            input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    pick = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = (last + int'(k)) % n;
      if ((int'(k) <= n) && req[idx[MAX_IDX_W-1:0]]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle between the bus sources (master side) and the arbiter
// (slave side). The shared tri-state bus itself is a separate wire port.
interface tristate_bus_arbiter_if
  import tri_bus_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int IDX_W = idx_w(N_REQ);

  // Handshake: req[i] is a level held by source i for as long as it wants the
  // bus. gnt[i] (registered) names the selected owner one cycle later; the
  // source may only consider its data on the bus while oe[i] is high, which
  // always follows gnt[i] by at least one dead turnaround cycle. Dropping
  // req[i] releases the bus: oe[i] falls on the next clock.
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        oe;
  logic [IDX_W-1:0]        owner;
  logic                    busy;
  logic [1:0]              state;

  modport master (
    output req, din,
    input  gnt, oe, owner, busy, state
  );

  modport slave (
    input  req, din,
    output gnt, oe, owner, busy, state
  );

endinterface

// File: rtl/tristate_bus_arbiter_drv.sv
// One tri-state output driver: passes 'a' onto y when enabled, else floats.
module tristate_drv #(
  parameter int DATA_W = 8
) (
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  output wire  [DATA_W-1:0] y
);

  assign y = en ? a : {DATA_W{1'bz}};

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus with a dead cycle at
// every ownership change. Optional hold-limit release: TRI_BUS_TIMEOUT_EN.
module tristate_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tristate_bus_arbiter_if.slave  arb,
  output wire  [DATA_W-1:0]      bus
);

  localparam int IDX_W = idx_w(N_REQ);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ARM   = ST_ARM;
  localparam logic [1:0] DRIVE = ST_DRIVE;

  if (N_REQ < 2 || N_REQ > MAX_REQ || MAX_HOLD < 1) begin : g_bad_params
    $error("tristate_bus_arbiter: unsupported N_REQ or MAX_HOLD");
  end

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] oe_q, oe_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             busy_q;

  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [N_REQ-1:0] others;
  logic             owner_req;
  logic             timeout;

  assign win_idx    = IDX_W'(rr_winner(MAX_REQ'(arb.req), 32'(last_q), N_REQ));
  assign win_onehot = N_REQ'(1) << win_idx;
  assign owner_req  = arb.req[owner_q];
  assign others     = arb.req & ~(N_REQ'(1) << owner_q);

`ifdef TRI_BUS_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q;

  // Counts DRIVE cycles of the current grant, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (state_q == ARM && owner_req) begin
      hold_q <= HOLD_W'(1);
    end else if (state_q == DRIVE && hold_q != HOLD_W'(MAX_HOLD)) begin
      hold_q <= hold_q + HOLD_W'(1);
    end
  end

  assign timeout = (state_q == DRIVE) && (hold_q == HOLD_W'(MAX_HOLD)) && (|others);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    oe_d    = oe_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|arb.req) begin
          state_d = ARM;
          gnt_d   = win_onehot;
          owner_d = win_idx;
          oe_d    = '0;
        end
      end
      ARM: begin
        if (owner_req) begin
          state_d = DRIVE;
          oe_d    = gnt_q;
          last_d  = owner_q;
        end else begin
          // Requester vanished during turnaround; fairness pointer untouched.
          state_d = IDLE;
          gnt_d   = '0;
          oe_d    = '0;
        end
      end
      DRIVE: begin
        if (!owner_req || timeout) begin
          oe_d = '0;
          if (|others) begin
            // last == owner here, so the search naturally skips the owner.
            state_d = ARM;
            gnt_d   = win_onehot;
            owner_d = win_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        oe_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      oe_q    <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= |oe_d;
    end
  end

  assign arb.gnt   = gnt_q;
  assign arb.oe    = oe_q;
  assign arb.owner = owner_q;
  assign arb.busy  = busy_q;
  assign arb.state = state_q;

  // All drivers share one net; oe is one-hot so at most one is ever active.
  for (genvar i = 0; i < N_REQ; i++) begin : g_drv
    tristate_drv #(
      .DATA_W(DATA_W)
    ) u_drv (
      .en(oe_q[i]),
      .a (arb.din[i*DATA_W +: DATA_W]),
      .y (bus)
    );
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench for tristate_bus_arbiter (N_REQ=4, DATA_W=8, MAX_HOLD=4);
// honours TRI_BUS_TIMEOUT_EN when defined.
module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  wire [W-1:0] bus;

  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.N_REQ(N), .DATA_W(W)) arb ();

  tristate_bus_arbiter #(
    .N_REQ(N), .DATA_W(W), .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(arb),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = nobody selected, 1 = selected but bus dead, 2 = owner driving
  int          m_phase;
  logic [N-1:0] m_gnt, m_oe, prev_oe;
  int          m_owner, m_last, m_held;
  logic [N-1:0] m_others;
  int          m_pick_all, m_pick_oth;
  logic        m_timeout;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return last;
  endfunction

  always_comb begin
    m_others   = arb.req & ~(N'(1) << m_owner);
    m_pick_all = pick(arb.req, m_last);
    m_pick_oth = pick(m_others, m_last);
`ifdef TRI_BUS_TIMEOUT_EN
    m_timeout  = (m_held >= MH) && (m_others != 0);
`else
    m_timeout  = 1'b0;
`endif
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_gnt   <= '0;
      m_oe    <= '0;
      m_owner <= 0;
      m_last  <= N - 1;
      m_held  <= 0;
    end else begin
      case (m_phase)
        0: if (arb.req != 0) begin
          m_phase <= 1;
          m_gnt   <= N'(1) << m_pick_all;
          m_owner <= m_pick_all;
        end
        1: if (arb.req[m_owner]) begin
          m_phase <= 2;
          m_oe    <= m_gnt;
          m_last  <= m_owner;
          m_held  <= 1;
        end else begin
          m_phase <= 0;
          m_gnt   <= '0;
        end
        default: begin
          if (!arb.req[m_owner] || m_timeout) begin
            m_oe <= '0;
            if (m_others != 0) begin
              m_phase <= 1;
              m_gnt   <= N'(1) << m_pick_oth;
              m_owner <= m_pick_oth;
            end else begin
              m_phase <= 0;
              m_gnt   <= '0;
            end
          end else if (m_held < MH) begin
            m_held <= m_held + 1;
          end
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt", arb.gnt, m_gnt);
      chk("oe", arb.oe, m_oe);
      chk("owner", arb.owner, m_owner);
      chk("busy", arb.busy, (m_oe != 0));
      chk("oe_onehot", ($countones(arb.oe) <= 1), 1);
      chk("gnt_onehot", ($countones(arb.gnt) <= 1), 1);
      if (prev_oe != 0 && arb.oe != 0) chk("dead_cycle", arb.oe, prev_oe);
      if (m_oe != 0) chk("bus", bus, arb.din[m_owner*W +: W]);
    end
    prev_oe <= arb.oe;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- scoreboard of drive order ----------------
  logic [W-1:0] exp_q[$];

  initial begin
    logic [W-1:0] e;
    logic [N-1:0] exp_oe;
    int tries;

    arb.req = '0;
    arb.din = 32'h3C5A_A596;  // din[0]=96 din[1]=A5 din[2]=5A din[3]=3C
    prev_oe = '0;

    #1;
    chk("rst_gnt", arb.gnt, 4'b0000);
    chk("rst_oe", arb.oe, 4'b0000);
    chk("rst_busy", arb.busy, 1'b0);
    chk("rst_owner", arb.owner, 2'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Round-robin: everyone requesting, each owner releases after 2 cycles.
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    exp_q.push_back(8'd3); exp_q.push_back(8'd0);
    arb.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tries = 0;
      while (arb.oe == 0 && tries < 8) begin
        tick();
        tries++;
      end
      if (arb.oe == 0) begin
        fail_now("rr_wait");
      end else begin
        e = exp_q.pop_front();
        chk("rr_owner", arb.owner, e);
        chk("rr_oe", arb.oe, N'(1) << e);
        tick();
        chk("rr_hold", arb.oe, N'(1) << e);
        arb.req[e[1:0]] = 1'b0;
        tick();
        chk("rr_dead", arb.oe, 4'b0000);
        arb.req[e[1:0]] = 1'b1;
      end
    end
    arb.req = '0;
    tick(); tick();

    // Single request from source 1.
    arb.req = 4'b0010;
    tick();
    chk("single_gnt", arb.gnt, 4'b0010);
    chk("single_oe0", arb.oe, 4'b0000);
    chk("single_busy0", arb.busy, 1'b0);
    tick();
    chk("single_oe", arb.oe, 4'b0010);
    chk("single_bus", bus, 8'hA5);
    chk("single_busy", arb.busy, 1'b1);
    tick();
    arb.req = '0;
    tick();
    chk("single_rel_oe", arb.oe, 4'b0000);
    chk("single_rel_gnt", arb.gnt, 4'b0000);
    tick();

    // Handover 2 -> 3 with a non-owner request arriving mid-drive.
    arb.req = 4'b0100;
    tick(); tick();
    chk("ho_oe2", arb.oe, 4'b0100);
    arb.req = 4'b1100;
    tick();
    chk("ho_undisturbed_gnt", arb.gnt, 4'b0100);
    chk("ho_undisturbed_oe", arb.oe, 4'b0100);
    arb.req = 4'b1000;
    tick();
    chk("ho_gnt3", arb.gnt, 4'b1000);
    chk("ho_dead", arb.oe, 4'b0000);
    tick();
    chk("ho_oe3", arb.oe, 4'b1000);
    chk("ho_bus3", bus, 8'h3C);
    arb.req = '0;
    tick(); tick();

    // Abandon: one-cycle pulse must not move the round-robin pointer (last=3).
    arb.req = 4'b0100;
    tick();
    chk("ab_gnt", arb.gnt, 4'b0100);
    chk("ab_oe", arb.oe, 4'b0000);
    arb.req = '0;
    tick();
    chk("ab_gnt0", arb.gnt, 4'b0000);
    chk("ab_oe0", arb.oe, 4'b0000);
    arb.req = 4'b1111;
    tick();
    chk("ab_next_gnt", arb.gnt, 4'b0001);
    tick();
    arb.req = '0;
    tick(); tick();

    // Asynchronous reset in the middle of a drive.
    arb.req = 4'b0100;
    tick(); tick();
    chk("ar_pre_oe", arb.oe, 4'b0100);
    #1 rst = 1'b1;
    #1;
    chk("ar_gnt", arb.gnt, 4'b0000);
    chk("ar_oe", arb.oe, 4'b0000);
    chk("ar_busy", arb.busy, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    arb.req = 4'b1111;
    tick();
    chk("ar_restart_gnt", arb.gnt, 4'b0001);
    arb.req = '0;
    tick(); tick();

    // Two persistent requesters: hold limit behaviour.
    arb.req = 4'b0011;
    for (int t = 1; t <= 21; t++) begin
      tick();
`ifdef TRI_BUS_TIMEOUT_EN
      if ((t - 1) % 5 == 0)               exp_oe = 4'b0000;
      else if (((t - 1) / 5) % 2 == 0)    exp_oe = 4'b0001;
      else                                exp_oe = 4'b0010;
`else
      exp_oe = (t == 1) ? 4'b0000 : 4'b0001;
`endif
      chk("hold_oe", arb.oe, exp_oe);
    end
    arb.req = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
